// File: rtl/mem_store_buffer_if.sv
// mem_store_buffer_if: Mem-stage store/load request, data-memory drain
// handshake and occupancy status for the posted-write store buffer.
// The "master" side is the pipeline plus data memory; the "slave" side is
// the store buffer itself.
interface mem_store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Mem-stage side
  logic          Mem_valid;
  logic [5:0]    Mem_op;
  logic [31:0]   Mem_addr;
  logic [31:0]   Mem_busB;
  logic          Mem_stall;
  logic          Mem_misalign;

  // data-memory write port
  logic          dm_req;
  logic [29:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic [3:0]    dm_be;
  logic          dm_ack;

  // status
  logic [CW-1:0] sb_count;
  logic          sb_empty;

  modport master (
    output Mem_valid, Mem_op, Mem_addr, Mem_busB, dm_ack,
    input  Mem_stall, Mem_misalign, dm_req, dm_addr, dm_wdata, dm_be,
           sb_count, sb_empty
  );

  modport slave (
    input  Mem_valid, Mem_op, Mem_addr, Mem_busB, dm_ack,
    output Mem_stall, Mem_misalign, dm_req, dm_addr, dm_wdata, dm_be,
           sb_count, sb_empty
  );
endinterface

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: posted-write FIFO between the Mem stage and data memory.
// Lane-aligns sb/sh/sw data, builds byte enables, queues up to DEPTH entries
// and drains them in order over dm_req/dm_ack.
// Optional feature macro: STORE_HAZARD_EN -- stall a load whose word address
// matches any pending entry. Undefined by default (loads never stall).
module mem_store_buffer #(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

  sb_entry_t       mem [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;

  logic            is_store, misalign, full, enq, deq, hazard;
  logic [31:0]     wdata;
  logic [3:0]      be;
  logic [1:0]      off;

  assign off = bus.Mem_addr[1:0];

  // Store decode: lane replication, byte enables and alignment check
  always_comb begin
    is_store = 1'b0;
    misalign = 1'b0;
    wdata    = bus.Mem_busB;
    be       = 4'b0000;
    case (bus.Mem_op)
      OP_SB: begin
        is_store = bus.Mem_valid;
        wdata    = {4{bus.Mem_busB[7:0]}};
        be       = 4'b0001 << off;
      end
      OP_SH: begin
        is_store = bus.Mem_valid;
        wdata    = {2{bus.Mem_busB[15:0]}};
        be       = off[1] ? 4'b1100 : 4'b0011;
        misalign = off[0];
      end
      OP_SW: begin
        is_store = bus.Mem_valid;
        be       = 4'b1111;
        misalign = (off != 2'b00);
      end
      default: ;
    endcase
  end

  // Full is decided from the count at the start of the cycle, so a drain in
  // the same cycle does not let the stalled store slip in early.
  assign full = (count == CW'(DEPTH));
  assign enq  = is_store && !misalign && !full;
  assign deq  = (count != '0) && bus.dm_ack;

`ifdef STORE_HAZARD_EN
  // Load-after-store hazard: word-granular match against occupied entries.
  logic             is_load;
  logic [DEPTH-1:0] hit;

  always_comb begin
    is_load = 1'b0;
    case (bus.Mem_op)
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101:
        is_load = bus.Mem_valid;
      default: ;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [AW-1:0] rel;
    // slot distance from head; occupied when it falls below the count
    assign rel    = AW'(i) - head;
    assign hit[i] = ({1'b0, rel} < count) && (mem[i].addr == bus.Mem_addr[31:2]);
  end

  assign hazard = is_load && (|hit);
`else
  assign hazard = 1'b0;
`endif

  assign bus.Mem_misalign = is_store && misalign;
  assign bus.Mem_stall    = (is_store && !misalign && full) || hazard;

  // Entry storage: written at the tail, never cleared
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= '{addr: bus.Mem_addr[31:2], wdata: wdata, be: be};
  end

  // Pointers and occupancy; full/empty come from count, not pointer equality
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + AW'(1);
      if (deq) head <= head + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.dm_req   = (count != '0);
  assign bus.dm_addr  = mem[head].addr;
  assign bus.dm_wdata = mem[head].wdata;
  assign bus.dm_be    = mem[head].be;
  assign bus.sb_count = count;
  assign bus.sb_empty = (count == '0);
endmodule

// File: doc/mem_store_buffer.md
# mem_store_buffer

Posted-write store buffer between the pipeline's Mem stage and the data memory port: the write-direction counterpart of the load/writeback path. Accepts `sb`/`sh`/`sw` from the Mem stage, lane-aligns the store data, generates byte enables, queues entries in a small FIFO, and drains them to data memory over a req/ack handshake. It stalls the Mem stage when full and, optionally, on a load that hits a pending store.

## Interface
- `DEPTH`, 4, number of buffer entries; must be a power of two and at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Mem_valid` in 1: Mem-stage instruction is valid this cycle.
- `Mem_op` in 6: opcode.
  - Stores: `101000` sb, `101001` sh, `101011` sw.
  - Loads: `100000` lb, `100001` lh, `100011` lw, `100100` lbu, `100101` lhu.
- `Mem_addr` in 32: effective byte address (ALU result).
- `Mem_busB` in 32: store data (rt value).
- `Mem_stall` out 1: hold the Mem stage and upstream this cycle.
- `Mem_misalign` out 1: store address misaligned; the store is dropped.
- `dm_req` out 1: head entry is presented to data memory.
- `dm_addr` out 30: word address `[31:2]` of the head entry.
- `dm_wdata` out 32: lane-replicated write data.
- `dm_be` out 4: byte enables; bit i enables byte lane i.
- `dm_ack` in 1: memory accepted the head entry this cycle.
- `sb_count` out 3: occupancy, 0..DEPTH. The width is sized for DEPTH=4; it is `$clog2(DEPTH)+1` in general.
- `sb_empty` out 1: `sb_count == 0`.

## Operation
- **Store classification.** A store is `Mem_valid` with a store opcode. Any other opcode is ignored, except for the hazard check.
- **Byte lanes are little-endian.** Byte address offset `a = Mem_addr[1:0]`.
  - sb: `be = 1 << a`; data = the replicated low byte, `{4{busB[7:0]}}`.
  - sh: `be = 0011` if `a[1]=0`, else `1100`; data = `{2{busB[15:0]}}`. Misaligned if `a[0]=1`.
  - sw: `be = 1111`; data = `busB`. Misaligned if `a != 0`.
- **Misaligned store.**
  - `Mem_misalign` is asserted combinationally that cycle.
  - No entry is written and `Mem_stall` is not asserted.
- **Enqueue.** A valid, aligned store with `sb_count < DEPTH` writes `{addr[31:2], wdata, be}` at the tail on the clock edge; the tail increments mod DEPTH.
- **Full.** A valid, aligned store with `sb_count == DEPTH` asserts `Mem_stall`.
  - The store is not written, even if a drain completes in the same cycle.
  - It retries next cycle.
- **Drain.**
  - `dm_req = !sb_empty`. `dm_addr`, `dm_wdata` and `dm_be` come from the head entry.
  - These outputs stay stable while `dm_req && !dm_ack`.
  - On `dm_req && dm_ack` the head increments mod DEPTH at the edge.
  - `dm_ack` while `dm_req=0` is ignored.
- **Simultaneous enqueue and dequeue.** `sb_count` is unchanged; both pointers advance.
- **Ordering.** Drain order equals enqueue order. No merging and no reordering.
- **Reset (asynchronous, including mid-operation).**
  - Pointers and count clear to 0 and all pending entries are discarded.
  - `dm_req` drops immediately (combinational from count).
  - Entry storage need not be cleared.

## Timing
- Reset values:
  - `sb_count=0`, `sb_empty=1`, `dm_req=0`.
  - `Mem_stall=0` and `Mem_misalign=0` when `Mem_valid=0`.
  - `dm_addr`, `dm_wdata` and `dm_be` are don't-care while `dm_req=0`.
- A store enqueued at edge N into an empty buffer gives `dm_req=1` in the cycle after edge N. Latency is one cycle from the Mem-stage cycle to the memory request.
- An ack in the cycle after edge M means the next entry (if any) is presented from edge M+1. Maximum throughput is one store per cycle.
- `Mem_stall`, `Mem_misalign`, `dm_req` and the `dm_*` outputs are combinational from inputs and registered state. No registered-output delay.
- Pointer wrap from DEPTH-1 to 0 is seamless; full and empty are distinguished by `sb_count`, not by pointer equality.

## Configuration
- **`STORE_HAZARD_EN` defined:**
  - A valid load whose `Mem_addr[31:2]` equals the word address of any occupied entry asserts `Mem_stall`.
  - The stall persists until the matching entries have drained.
  - The comparison is word-granular and ignores byte enables.
- **`STORE_HAZARD_EN` not defined:**
  - Loads never stall.
  - Software or the memory system guarantees read-after-write ordering.
  - The comparator logic is absent.

## Test plan
- **Reset, then store.** Reset, then `sw` with addr `0x100` and busB `0xDEADBEEF` -> next cycle `dm_req=1`, `dm_addr=0x40`, `dm_wdata=0xDEADBEEF`, `dm_be=1111`; ack -> `sb_empty=1`.
- **Byte and half lanes.** `sb` addr `0x203`, busB `0x000000A5` -> `dm_be=1000`, `dm_wdata=0xA5A5A5A5`; `sh` addr `0x202`, busB `0x1234` -> `dm_be=1100`, `dm_wdata=0x12341234`.
- **Misaligned stores.** `sh` addr `0x201` or `sw` addr `0x102` -> `Mem_misalign=1`, `Mem_stall=0`, `sb_count` unchanged.
- **Full and ordered drain.** Hold `dm_ack=0` and issue 5 stores -> `sb_count=4`, `Mem_stall=1` on the 5th. Raise ack for one cycle with the 5th still presented -> the 5th is not written that cycle, is accepted the next cycle, and all 5 drain in issue order.
- **Concurrent traffic and wrap.** With `dm_ack=1` constantly, issue 10 back-to-back stores -> `sb_count` never exceeds 1 and pointers wrap. Assert `rst_n=0` with 3 pending -> `dm_req=0` immediately and no further requests after release.
- **Load hazard.** With `STORE_HAZARD_EN`: pending `sw` to `0x300`, then `lw` at `0x302` -> `Mem_stall=1` until acked, then 0. Without the macro -> `Mem_stall=0`.
